// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V front end.
package riscv_pkg;

    localparam int              ADDR_W    = 16;
    localparam int              INSTR_W   = 32;
    localparam logic [15:0]     RESET_PC  = 16'h0000;
    localparam logic [31:0]     INSTR_NOP = 32'h0000_0013;
    localparam int              PC_INC    = 4;

    typedef enum logic {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous instruction buffer with flush and a registered head word.
module riscv_fetch_fifo #(
    parameter int  DATA_W = 48,
    parameter int  DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  cnt_after_pop;
    logic              do_pop;
    logic              do_push;

    assign empty         = (count == '0);
    assign full          = (count == CNT_W'(DEPTH));
    assign do_pop        = pop & ~empty;
    assign do_push       = push & (~full | do_pop);
    assign cnt_after_pop = count - CNT_W'(do_pop);
    assign rd_ptr_nxt    = rd_ptr + PTR_W'(do_pop);

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head register is loaded with whatever will sit at the read pointer
    // after this cycle, so the output is registered without a bubble.
    always_ff @(posedge CLK) begin
        if (!RST || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count <= cnt_after_pop + CNT_W'(do_push);
            if (cnt_after_pop != '0) begin
                head <= mem[rd_ptr_nxt];
            end else if (do_push) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch: sequential PC, credit-limited imem requests, redirect/discard tracking.
module riscv_fetch #(
    parameter int                ADDR_W     = riscv_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(riscv_pkg::RESET_PC),
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    import riscv_pkg::*;

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_W = ADDR_W + INSTR_W;

    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(PC_INC);
    endfunction

    function automatic logic [ADDR_W-1:0] pc_align(input logic [ADDR_W-1:0] pc);
        return pc & ~ADDR_W'(3);
    endfunction

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic              rsp_en;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] resp_pc_q;
    logic [CNT_W-1:0]  outstanding_q;
    logic [CNT_W-1:0]  outstanding_d;
    logic [CNT_W-1:0]  discard_q;
    logic [CNT_W:0]    in_use;

    logic              issue;
    logic              rsp_accept;
    logic              rsp_keep;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [FIFO_W-1:0] fifo_head;

    // Responses are only honoured once a full cycle of RUN has elapsed, so a
    // reply to a request issued before reset cannot slip into the new stream.
    always_comb begin
        state_d = state_q;
        rsp_en  = 1'b0;
        case (state_q)
            ST_RESET: begin
                rsp_en  = 1'b0;
                state_d = RST ? ST_RUN : ST_RESET;
            end
            ST_RUN: begin
                rsp_en  = 1'b1;
                state_d = RST ? ST_RUN : ST_RESET;
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_use     = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req   = RST & ~redirect_valid & (in_use < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_addr  = pc_q;
    assign issue      = imem_req & imem_gnt;
    assign rsp_accept = imem_rvalid & rsp_en & (outstanding_q != '0);
    assign rsp_keep   = rsp_accept & (discard_q == '0) & ~redirect_valid;

    assign outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rsp_accept);

    // On a redirect every request still in flight after this cycle belongs to
    // the abandoned path, so the discard count is simply the new outstanding.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (redirect_valid) begin
                pc_q      <= pc_align(redirect_pc);
                resp_pc_q <= pc_align(redirect_pc);
                discard_q <= outstanding_d;
            end else begin
                if (issue) begin
                    pc_q <= pc_next(pc_q);
                end
                if (rsp_keep) begin
                    resp_pc_q <= pc_next(resp_pc_q);
                end
                if (rsp_accept && (discard_q != '0)) begin
                    discard_q <= discard_q - CNT_W'(1);
                end
            end
        end
    end

    assign fifo_pop  = if_valid & if_ready;
    assign fifo_push = rsp_keep & (~fifo_full | fifo_pop);

    riscv_fetch_fifo #(
        .DATA_W (FIFO_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (fifo_push),
        .push_data ({resp_pc_q, imem_rdata}),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head      (fifo_head)
    );

    assign if_valid = ~fifo_empty;
    assign if_pc    = fifo_head[FIFO_W-1:INSTR_W];
    assign if_instr = fifo_head[INSTR_W-1:0];

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch with an in-order, variable-latency memory model.
module tb_riscv_fetch;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [15:0] if_pc;

    always #5 CLK = ~CLK;

    riscv_fetch #(
        .ADDR_W     (16),
        .RESET_PC   (16'h0000),
        .FIFO_DEPTH (2)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [15:0] iss[$];
    logic [15:0] gpc[$];
    logic [31:0] gins[$];
    int          cyc    = 0;
    int          lat    = 1;
    bit          gnt_en = 1'b1;
    int          n_cmp  = 0;
    int          n_mis  = 0;

    function automatic logic [31:0] mdata(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: memory answers in order, grants are logged, consumed words logged.
    task automatic step();
        mreq_t m;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m           = mq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mdata(m.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        imem_gnt = gnt_en;
        #1;
        if (imem_req && imem_gnt) begin
            m.addr = imem_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
            iss.push_back(imem_addr);
        end
        if (if_valid && if_ready) begin
            gpc.push_back(if_pc);
            gins.push_back(if_instr);
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic clear_logs();
        iss.delete();
        gpc.delete();
        gins.delete();
    endtask

    task automatic chk_got(input string tag, input int i, input logic [15:0] exp);
        if (i < gpc.size()) begin
            chk({tag, "_pc"}, 48'(gpc[i]), 48'(exp));
            chk({tag, "_ins"}, 48'(gins[i]), 48'(mdata(exp)));
        end else begin
            chk({tag, "_missing"}, 48'(gpc.size()), 48'(i + 1));
        end
    endtask

    task automatic chk_iss(input string tag, input int i, input logic [15:0] exp);
        if (i < iss.size()) begin
            chk(tag, 48'(iss[i]), 48'(exp));
        end else begin
            chk({tag, "_missing"}, 48'(iss.size()), 48'(i + 1));
        end
    endtask

    initial begin
        RST            = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        if_ready       = 1'b1;

        // Reset, then a lat-1 stream
        repeat (3) step();
        chk("rst_valid", 48'(if_valid), 48'(0));
        chk("rst_pc",    48'(if_pc),    48'(0));
        chk("rst_instr", 48'(if_instr), 48'(0));
        chk("rst_addr",  48'(imem_addr), 48'(16'h0000));
        chk("rst_req",   48'(imem_req), 48'(0));
        RST = 1'b1;
        step();
        chk("lat_t1_valid", 48'(if_valid), 48'(0));
        step();
        chk("lat_t2_valid", 48'(if_valid), 48'(1));
        chk("lat_t2_pc",    48'(if_pc),    48'(16'h0000));
        chk("lat_t2_instr", 48'(if_instr), 48'(mdata(16'h0000)));
        repeat (8) step();
        chk("stream_cnt", 48'(gpc.size()), 48'(6));
        chk_got("stream0", 0, 16'h0000);
        chk_got("stream1", 1, 16'h0004);
        chk_got("stream2", 2, 16'h0008);
        chk_got("stream3", 3, 16'h000C);
        chk_iss("stream_addr0", 0, 16'h0000);
        chk_iss("stream_addr1", 1, 16'h0004);
        chk_iss("stream_addr2", 2, 16'h0008);
        chk_iss("stream_addr3", 3, 16'h000C);

        // Decode stall fills the buffer and throttles requests
        clear_logs();
        if_ready = 1'b0;
        repeat (2) step();
        chk("stall_pc_early", 48'(if_pc), 48'(16'h0018));
        repeat (3) step();
        chk("stall_valid", 48'(if_valid), 48'(1));
        chk("stall_pc",    48'(if_pc),    48'(16'h0018));
        chk("stall_instr", 48'(if_instr), 48'(mdata(16'h0018)));
        chk("stall_req",   48'(imem_req), 48'(0));
        if_ready = 1'b1;
        repeat (6) step();
        chk("release_cnt", 48'(gpc.size()), 48'(4));
        chk_got("release0", 0, 16'h0018);
        chk_got("release1", 1, 16'h001C);
        chk_got("release2", 2, 16'h0020);
        chk_got("release3", 3, 16'h0024);

        // Unaligned redirect, then a redirect with two requests in flight
        clear_logs();
        if_ready       = 1'b0;
        lat            = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0012;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        chk("redir_flush", 48'(if_valid),  48'(0));
        chk("redir_align", 48'(imem_addr), 48'(16'h0010));
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        step();
        redirect_valid = 1'b0;
        repeat (4) step();
        chk("redir_drop", 48'(if_valid), 48'(0));
        step();
        chk("redir_valid", 48'(if_valid), 48'(1));
        chk("redir_pc",    48'(if_pc),    48'(16'h0100));
        chk("redir_instr", 48'(if_instr), 48'(mdata(16'h0100)));
        step();
        step();
        chk_iss("redir_addr0", 0, 16'h0010);
        chk_iss("redir_addr1", 1, 16'h0014);
        chk_iss("redir_addr2", 2, 16'h0100);
        chk_iss("redir_addr3", 3, 16'h0104);
        chk("redir_cnt", 48'(gpc.size()), 48'(2));
        chk_got("redir0", 0, 16'h0100);
        chk_got("redir1", 1, 16'h0104);

        // Wait states: three ungranted cycles, then latency 4
        gnt_en = 1'b0;
        repeat (8) step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        step();
        clear_logs();
        redirect_valid = 1'b0;
        #1;
        chk("ws_addr0", 48'(imem_addr), 48'(16'h0200));
        chk("ws_req0",  48'(imem_req),  48'(1));
        step();
        chk("ws_addr1", 48'(imem_addr), 48'(16'h0200));
        chk("ws_req1",  48'(imem_req),  48'(1));
        step();
        chk("ws_addr2", 48'(imem_addr), 48'(16'h0200));
        step();
        gnt_en = 1'b1;
        lat    = 4;
        repeat (13) step();
        chk_iss("ws_iss0", 0, 16'h0200);
        chk_iss("ws_iss1", 1, 16'h0204);
        chk_iss("ws_iss2", 2, 16'h0208);
        chk_iss("ws_iss3", 3, 16'h020C);
        chk_got("ws0", 0, 16'h0200);
        chk_got("ws1", 1, 16'h0204);
        chk_got("ws2", 2, 16'h0208);
        chk_got("ws3", 3, 16'h020C);

        // PC wrap at the top of the address space
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFF8;
        step();
        clear_logs();
        redirect_valid = 1'b0;
        repeat (15) step();
        chk_got("wrap0", 0, 16'hFFF8);
        chk_got("wrap1", 1, 16'hFFFC);
        chk_got("wrap2", 2, 16'h0000);
        chk_iss("wrap_addr0", 0, 16'hFFF8);
        chk_iss("wrap_addr1", 1, 16'hFFFC);
        chk_iss("wrap_addr2", 2, 16'h0000);

        // Reset with two requests outstanding
        gnt_en = 1'b0;
        repeat (6) step();
        gnt_en = 1'b1;
        lat    = 3;
        step();
        step();
        RST = 1'b0;
        step();
        chk("midrst_valid", 48'(if_valid),  48'(0));
        chk("midrst_pc",    48'(if_pc),     48'(0));
        chk("midrst_instr", 48'(if_instr),  48'(0));
        chk("midrst_addr",  48'(imem_addr), 48'(16'h0000));
        chk("midrst_late_pending", 48'(mq.size()), 48'(2));
        if (mq.size() > 1) mq.delete(1);
        RST = 1'b1;
        clear_logs();
        step();
        chk("midrst_late_drop", 48'(if_valid), 48'(0));
        repeat (8) step();
        chk_iss("midrst_addr0", 0, 16'h0000);
        chk_iss("midrst_addr1", 1, 16'h0004);
        chk_got("midrst0", 0, 16'h0000);
        chk_got("midrst1", 1, 16'h0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
